// File: rtl/operand_aligner_pkg.sv
// Shared FP32 field widths, alignment width and the unpacked-operand type
// for the operand aligner.
package operand_aligner_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int MAN_W   = FRAC_W + 1;
   localparam int ALIGN_W = 27;
   localparam int SHAMT_W = 9;

   localparam logic [EXP_W-1:0] EXP_INF = 8'd255;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } unpacked_t;

   // Subnormals and zero read as effective exponent 1 with hidden bit 0.
   function automatic unpacked_t unpack(input logic [31:0] f);
      unpacked_t u;
      u.sign = f[31];
      if (f[30:23] == '0) begin
         u.exp = 8'd1;
         u.man = {1'b0, f[22:0]};
      end else begin
         u.exp = f[30:23];
         u.man = {1'b1, f[22:0]};
      end
      return u;
   endfunction

endpackage

// File: rtl/operand_aligner_align_shifter.sv
// Saturating right shift of a 27-bit aligned mantissa. With STICKY_EN defined,
// bit 0 collects the OR of everything shifted out; otherwise bit 0 is forced 0.
module align_shifter
   import operand_aligner_pkg::*;
(
   input  logic [ALIGN_W-1:0] man_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [ALIGN_W-1:0] man_o
);

   localparam logic [SHAMT_W-1:0] SAT_AMT = SHAMT_W'(ALIGN_W);

   logic               sat;
   logic [4:0]         sh;
   logic [ALIGN_W-1:0] shifted;

   assign sat     = (shamt_i >= SAT_AMT);
   assign sh      = sat ? 5'(ALIGN_W) : shamt_i[4:0];
   assign shifted = sat ? '0 : (man_i >> sh);

`ifdef STICKY_EN
   logic [ALIGN_W-1:0] lost_mask;
   logic               sticky;

   // A shift of ALIGN_W pushes the all-ones pattern out entirely, so the
   // mask covers the whole mantissa in the saturated case.
   assign lost_mask = ~({ALIGN_W{1'b1}} << sh);
   assign sticky    = |(man_i & lost_mask);
   assign man_o     = {shifted[ALIGN_W-1:1], shifted[0] | sticky};
`else
   assign man_o     = shifted & ~ALIGN_W'(1);
`endif

endmodule

// File: rtl/operand_aligner.sv
// Two-stage FP32 operand aligner: stage 1 unpacks and compares exponents,
// stage 2 shifts the smaller operand. Optional sticky collection: STICKY_EN.
module operand_aligner
   import operand_aligner_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_a,
   input  logic [31:0]        in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EXP_W-1:0]   out_exp_max,
   output logic [ALIGN_W-1:0] out_man_a,
   output logic [ALIGN_W-1:0] out_man_b,
   output logic               out_sign_a,
   output logic               out_sign_b,
   output logic               out_swap,
   output logic               out_special
);

   logic adv;

   unpacked_t          op_a_d, op_b_d, op_a_p1_q, op_b_p1_q;
   logic [EXP_W-1:0]   exp_max_d, exp_max_p1_q;
   logic [SHAMT_W-1:0] diff_d, diff_p1_q;
   logic               swap_d, swap_p1_q;
   logic               special_d, special_p1_q;
   logic               vld_p1_q;

   logic [ALIGN_W-1:0] shift_in, ref_man, shifted;
   logic [ALIGN_W-1:0] man_a_d, man_b_d;

   logic               vld_p2_q;
   logic [EXP_W-1:0]   exp_max_p2_q;
   logic [ALIGN_W-1:0] man_a_p2_q, man_b_p2_q;
   logic               sign_a_p2_q, sign_b_p2_q, swap_p2_q, special_p2_q;

   // Whole pipe moves in lockstep; a stalled output freezes both stages.
   assign adv      = !vld_p2_q || out_ready;
   assign in_ready = adv;

   // ---- stage 1: unpack, exponent compare ----
   always_comb begin
      op_a_d    = unpack(in_a);
      op_b_d    = unpack(in_b);
      swap_d    = (op_b_d.exp > op_a_d.exp);
      exp_max_d = swap_d ? op_b_d.exp : op_a_d.exp;
      diff_d    = swap_d ? ({1'b0, op_b_d.exp} - {1'b0, op_a_d.exp})
                         : ({1'b0, op_a_d.exp} - {1'b0, op_b_d.exp});
      special_d = (in_a[30:23] == EXP_INF) || (in_b[30:23] == EXP_INF);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q     <= 1'b0;
         op_a_p1_q    <= '0;
         op_b_p1_q    <= '0;
         exp_max_p1_q <= '0;
         diff_p1_q    <= '0;
         swap_p1_q    <= 1'b0;
         special_p1_q <= 1'b0;
      end else if (adv) begin
         vld_p1_q     <= in_valid;
         op_a_p1_q    <= op_a_d;
         op_b_p1_q    <= op_b_d;
         exp_max_p1_q <= exp_max_d;
         diff_p1_q    <= diff_d;
         swap_p1_q    <= swap_d;
         special_p1_q <= special_d;
      end
   end

   // ---- stage 2: shift the smaller-exponent operand ----
   always_comb begin
      shift_in = swap_p1_q ? {op_a_p1_q.man, 3'b000} : {op_b_p1_q.man, 3'b000};
      ref_man  = swap_p1_q ? {op_b_p1_q.man, 3'b000} : {op_a_p1_q.man, 3'b000};
      man_a_d  = swap_p1_q ? shifted : ref_man;
      man_b_d  = swap_p1_q ? ref_man : shifted;
   end

   align_shifter u_shifter (
      .man_i   (shift_in),
      .shamt_i (diff_p1_q),
      .man_o   (shifted)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2_q     <= 1'b0;
         exp_max_p2_q <= '0;
         man_a_p2_q   <= '0;
         man_b_p2_q   <= '0;
         sign_a_p2_q  <= 1'b0;
         sign_b_p2_q  <= 1'b0;
         swap_p2_q    <= 1'b0;
         special_p2_q <= 1'b0;
      end else if (adv) begin
         vld_p2_q     <= vld_p1_q;
         exp_max_p2_q <= exp_max_p1_q;
         man_a_p2_q   <= man_a_d;
         man_b_p2_q   <= man_b_d;
         sign_a_p2_q  <= op_a_p1_q.sign;
         sign_b_p2_q  <= op_b_p1_q.sign;
         swap_p2_q    <= swap_p1_q;
         special_p2_q <= special_p1_q;
      end
   end

   assign out_valid   = vld_p2_q;
   assign out_exp_max = exp_max_p2_q;
   assign out_man_a   = man_a_p2_q;
   assign out_man_b   = man_b_p2_q;
   assign out_sign_a  = sign_a_p2_q;
   assign out_sign_b  = sign_b_p2_q;
   assign out_swap    = swap_p2_q;
   assign out_special = special_p2_q;

endmodule

// File: tb/tb_operand_aligner.sv
// Bench for operand_aligner: fixed vectors, stall/reset sequences and a
// randomized stream scored against an arithmetic model of the alignment rules.
module tb_operand_aligner;

`ifdef STICKY_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_exp_max;
   logic [26:0] out_man_a, out_man_b;
   logic        out_sign_a, out_sign_b, out_swap, out_special;

   always #5 clk = ~clk;

   operand_aligner dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_exp_max (out_exp_max),
      .out_man_a   (out_man_a),
      .out_man_b   (out_man_b),
      .out_sign_a  (out_sign_a),
      .out_sign_b  (out_sign_b),
      .out_swap    (out_swap),
      .out_special (out_special)
   );

   typedef struct packed {
      logic [7:0]  e;
      logic [26:0] ma;
      logic [26:0] mb;
      logic        sa;
      logic        sb;
      logic        sw;
      logic        sp;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      res_t        exp;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   n_out  = 0;
   res_t expq[$];
   res_t prev;
   bit   prev_stall = 1'b0;
   bit   rnd_done = 1'b0;

   function automatic res_t cur();
      return {out_exp_max, out_man_a, out_man_b, out_sign_a, out_sign_b, out_swap, out_special};
   endfunction

   // Alignment written as integer arithmetic: value / 2^d with remainder as sticky.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
      res_t   r;
      int     ea, eb, d;
      longint ma, mb, sm, sh, lost;
      ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
      eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
      ma = (((a[30:23] != 0) ? (longint'(1) << 23) : 0) + longint'(a[22:0])) * 8;
      mb = (((b[30:23] != 0) ? (longint'(1) << 23) : 0) + longint'(b[22:0])) * 8;
      r.sw = (eb > ea);
      r.e  = 8'(r.sw ? eb : ea);
      d    = r.sw ? eb - ea : ea - eb;
      sm   = r.sw ? ma : mb;
      if (d >= 27) begin
         sh = 0;
         lost = sm;
      end else begin
         sh = sm / (longint'(1) << d);
         lost = sm % (longint'(1) << d);
      end
      if (STK) begin
         if (lost != 0) sh = sh | 1;
      end else begin
         sh = sh & ~longint'(1);
      end
      r.ma = 27'(r.sw ? sh : ma);
      r.mb = 27'(r.sw ? mb : sh);
      r.sa = a[31];
      r.sb = b[31];
      r.sp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
      return r;
   endfunction

   // Scoreboard, stall checks and handshake bookkeeping, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!out_valid || cur() !== prev) begin
               errors++;
               $display("FAIL stall_hold: got vld=%0b %h, required vld=1 %h", out_valid, cur(), prev);
            end
         end
         if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_in_ready: got %0b, required 0", in_ready);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            n_out++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got %h, required no output", cur());
            end else begin
               res_t e;
               e = expq.pop_front();
               if (cur() !== e) begin
                  errors++;
                  $display("FAIL result: got %h, required %h", cur(), e);
               end
            end
         end
         if (in_valid && in_ready) expq.push_back(model(in_a, in_b));
         prev_stall = out_valid && !out_ready;
         prev = cur();
      end
   end

   // Called at posedge+1; returns at posedge+1 after the pair was accepted.
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   vec_t vt[9];

   initial begin
      vt[0] = '{32'h3F800000, 32'h3F800000, '{8'd127, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[1] = '{32'hBF000000, 32'h3F800000, '{8'd127, 27'h2000000, 27'h4000000, 1'b1, 1'b0, 1'b1, 1'b0}};
      vt[2] = '{32'h3F800000, 32'h30800001, '{8'd127, 27'h4000000, STK ? 27'h1 : 27'h0, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[3] = '{32'h00000000, 32'h3F800000, '{8'd127, 27'h0, 27'h4000000, 1'b0, 1'b0, 1'b1, 1'b0}};
      vt[4] = '{32'h7FC00000, 32'h3F800000, '{8'd255, 27'h6000000, STK ? 27'h1 : 27'h0, 1'b0, 1'b0, 1'b0, 1'b1}};
      vt[5] = '{32'h00000001, 32'h80800000, '{8'd1, 27'h8, 27'h4000000, 1'b0, 1'b1, 1'b0, 1'b0}};
      vt[6] = '{32'h3F800000, 32'h32800000, '{8'd127, 27'h4000000, STK ? 27'h1 : 27'h0, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[7] = '{32'h3F800000, 32'h3E000007, '{8'd127, 27'h4000000, STK ? 27'h800007 : 27'h800006, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[8] = '{32'h3F800000, 32'hFF800000, '{8'd255, STK ? 27'h1 : 27'h0, 27'h4000000, 1'b0, 1'b1, 1'b1, 1'b1}};

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || cur() !== '0) begin
         errors++;
         $display("FAIL reset_state: got vld=%0b rdy=%0b %h, required vld=0 rdy=1 0", out_valid, in_ready, cur());
      end
      @(posedge clk);
      #1;

      // Directed vectors, one pair at a time
      for (int v = 0; v < 9; v++) begin
         bit seen;
         seen = 1'b0;
         send(vt[v].a, vt[v].b);
         in_valid = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
               seen = 1'b1;
               break;
            end
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL vec%0d_timeout: got no out_valid, required a result", v);
         end else if (cur() !== vt[v].exp) begin
            errors++;
            $display("FAIL vec%0d: got %h, required %h", v, cur(), vt[v].exp);
         end
         @(posedge clk);
         #1;
      end

      // Four-pair stream with a three-cycle downstream stall
      begin
         int base;
         base = n_out;
         fork
            begin
               send(32'h3F800000, 32'h40000000);
               send(32'hC1200000, 32'h3DCCCCCD);
               send(32'h00400000, 32'h00000003);
               send(32'h7F800000, 32'h42F60000);
               in_valid = 1'b0;
            end
            begin
               for (int i = 0; i < 20; i++) begin
                  @(posedge clk);
                  #1;
                  if (out_valid) break;
               end
               out_ready = 1'b0;
               repeat (3) @(posedge clk);
               #1 out_ready = 1'b1;
            end
         join
         repeat (8) @(posedge clk);
         #1;
         checks++;
         if (n_out - base != 4 || expq.size() != 0) begin
            errors++;
            $display("FAIL stall_stream: got %0d results (%0d pending), required 4 (0 pending)", n_out - base, expq.size());
         end
      end

      // Reset one cycle after an accept discards the pair
      begin
         int base;
         send(32'h40400000, 32'h3F800000);
         in_valid = 1'b0;
         rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || cur() !== '0) begin
            errors++;
            $display("FAIL reset_flush: got vld=%0b rdy=%0b %h, required vld=0 rdy=1 0", out_valid, in_ready, cur());
         end
         base = n_out;
         repeat (10) @(posedge clk);
         #1;
         checks++;
         if (n_out != base) begin
            errors++;
            $display("FAIL reset_no_emit: got %0d results, required 0", n_out - base);
         end
      end

      // Randomized stream with random back-pressure
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               logic [31:0] a, b;
               int          eb;
               a = $urandom;
               b = $urandom;
               if ($urandom_range(0, 1) == 1) begin
                  eb = int'(a[30:23]) + $urandom_range(0, 60) - 30;
                  if (eb < 0) eb = 0;
                  if (eb > 255) eb = 255;
                  b[30:23] = 8'(eb);
               end
               if ($urandom_range(0, 9) == 0) b[30:23] = 8'h00;
               if ($urandom_range(0, 4) == 0) idle_cycle();
               send(a, b);
            end
            in_valid = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL random_drain: got %0d pending results, required 0", expq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
